// File: rtl/prog_loader.sv
// Byte-stream program loader: A5 sync, 16-bit big-endian word count, big-endian 32-bit words into imem.
// Define PROG_LOADER_CSUM_EN to add a trailing XOR checksum byte and the CSUM check state.
module prog_loader (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        clear,
  output logic        cpu_hold,
  output logic        imem_we,
  output logic [9:0]  imem_addr,
  output logic [31:0] imem_wdata,
  output logic        done,
  output logic        err,
  output logic [10:0] words_loaded
);

  typedef enum logic [2:0] {
    IDLE, CNT_HI, CNT_LO, DATA,
`ifdef PROG_LOADER_CSUM_EN
    CSUM,
`endif
    DONE, ERR
  } state_t;

`ifdef PROG_LOADER_CSUM_EN
  localparam state_t AFTER_DATA = CSUM;
`else
  localparam state_t AFTER_DATA = DONE;
`endif

  state_t      state, state_next;
  logic [15:0] cnt;
  logic [15:0] cnt_full;
  logic [1:0]  byte_idx;
  logic [10:0] word_idx;
  logic [23:0] word_buf;
  logic        accept;
  logic        last_word;
`ifdef PROG_LOADER_CSUM_EN
  logic [7:0]  xor_acc;
`endif

  assign accept    = in_valid & in_ready;
  assign cnt_full  = {cnt[15:8], in_data};
  assign last_word = (word_idx + 11'd1) == cnt[10:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b1;
    done       = 1'b0;
    err        = 1'b0;
    cpu_hold   = 1'b1;
    case (state)
      IDLE:   if (accept && in_data == 8'hA5) state_next = CNT_HI;
      CNT_HI: if (accept) state_next = CNT_LO;
      CNT_LO: begin
        if (accept) begin
          if (cnt_full > 16'd1024)     state_next = ERR;
          else if (cnt_full == 16'd0)  state_next = AFTER_DATA;
          else                         state_next = DATA;
        end
      end
      DATA:   if (accept && byte_idx == 2'd3 && last_word) state_next = AFTER_DATA;
`ifdef PROG_LOADER_CSUM_EN
      CSUM:   if (accept) state_next = (in_data == xor_acc) ? DONE : ERR;
`endif
      DONE: begin
        in_ready = 1'b0;
        done     = 1'b1;
        cpu_hold = 1'b0;
        if (clear) state_next = IDLE;
      end
      ERR: begin
        in_ready = 1'b0;
        err      = 1'b1;
        if (clear) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Datapath: the write is registered so imem_we lands the cycle after the 4th byte.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt          <= '0;
      byte_idx     <= '0;
      word_idx     <= '0;
      word_buf     <= '0;
      imem_we      <= 1'b0;
      imem_addr    <= '0;
      imem_wdata   <= '0;
      words_loaded <= '0;
`ifdef PROG_LOADER_CSUM_EN
      xor_acc      <= '0;
`endif
    end else begin
      imem_we <= 1'b0;
      if (accept) begin
        case (state)
          IDLE: begin
            if (in_data == 8'hA5) begin
              byte_idx     <= '0;
              word_idx     <= '0;
              words_loaded <= '0;
`ifdef PROG_LOADER_CSUM_EN
              xor_acc      <= '0;
`endif
            end
          end
          CNT_HI: cnt[15:8] <= in_data;
          CNT_LO: cnt       <= cnt_full;
          DATA: begin
            if (byte_idx == 2'd3) begin
              imem_we      <= 1'b1;
              imem_addr    <= word_idx[9:0];
              imem_wdata   <= {word_buf, in_data};
              word_idx     <= word_idx + 11'd1;
              words_loaded <= words_loaded + 11'd1;
              byte_idx     <= '0;
            end else begin
              word_buf <= {word_buf[15:0], in_data};
              byte_idx <= byte_idx + 2'd1;
            end
          end
          default: ;
        endcase
`ifdef PROG_LOADER_CSUM_EN
        if (state == CNT_HI || state == CNT_LO || state == DATA)
          xor_acc <= xor_acc ^ in_data;
`endif
      end
    end
  end

endmodule
